dvfs_pstate_sequencer: RTL and testbench
========================================

// Module: dvfs_pstate_sequencer
// PURPOSE
//  Sequences P-state changes into advanced_power_manager via its frequency/voltage override ports.
//  Moves one code per step with safe ordering: voltage before frequency going up, frequency before voltage going down.
//  Waits a programmable settle time after every override write.
//  Auto-throttles one step down when measured power exceeds the budget; serialises software requests via valid/ready.
// PARAMETERS
//  PSTATE_W    3  width of P-state / override codes
//  MAX_PSTATE  6  highest legal code; requests above it are rejected
//  SETTLE_W    8  width of settle-cycle config and counter
// PORTS
//  clk                 in   1         clock
//  reset_n             in   1         async active-low reset
//  req_valid           in   1         P-state change request
//  req_ready           out  1         high when a request can be accepted
//  req_pstate          in   PSTATE_W  target P-state code
//  power_budget_mw     in   16        power budget
//  current_power_mw    in   16        measured power from power manager
//  volt_settle_cycles  in   SETTLE_W  cycles to wait after a voltage write (0 treated as 1)
//  freq_settle_cycles  in   SETTLE_W  cycles to wait after a frequency write (0 treated as 1)
//  frequency_override_en out 1        to power manager
//  frequency_override  out  PSTATE_W  to power manager
//  voltage_override_en out  1         to power manager
//  voltage_override    out  PSTATE_W  to power manager
//  cur_pstate          out  PSTATE_W  committed state (= frequency_override)
//  busy                out  1         high in any state other than IDLE
//  done_pulse          out  1         1-cycle pulse on completion (request or throttle)
//  reject_pulse        out  1         1-cycle pulse on rejected request
//  throttle_active     out  1         high while an auto-throttle step is in flight
// BEHAVIOUR
//  Reset (async, immediate, also mid-transition): all outputs 0 except req_ready=1; FSM to IDLE; counters 0.
//  FSM states and transitions:
//    IDLE -> V_STEP | F_STEP | DONE; V_STEP -> V_WAIT; F_STEP -> F_WAIT; V_WAIT/F_WAIT -> next step or DONE; DONE -> IDLE.
//  IDLE arbitration, evaluated each cycle, first match wins:
//   1. Throttle: current_power_mw > power_budget_mw and cur_pstate > 0.
//      Start a 1-step down move with throttle_active=1; req_ready=0 this cycle.
//   2. Request: req_valid && req_ready.
//      req_pstate > MAX_PSTATE -> reject_pulse next cycle, no state change.
//      req_pstate > cur_pstate while over budget -> reject_pulse.
//      req_pstate == cur_pstate -> DONE next cycle.
//      Otherwise latch target and start the move.
//  req_ready = (state==IDLE) && !throttle condition.
//  Step rules:
//   - STEP states last 1 cycle; the override register is written +/-1 and is visible the next cycle.
//   - Both *_override_en go to 1 on the first write and stay 1 until reset.
//   - Up step: V_STEP, V_WAIT (volt_settle), F_STEP, F_WAIT (freq_settle).
//   - Down step: F_STEP, F_WAIT (freq_settle), V_STEP, V_WAIT (volt_settle).
//   - WAIT states count the config value (sampled on entry, min 1), then start the next step, or go to DONE when frequency_override==target.
//   - DONE lasts 1 cycle and asserts done_pulse; throttle_active clears at DONE.
//  Latency from accept cycle A, with Sv/Sf the effective settle counts and k the number of steps:
//   - done_pulse at A + k*(2+Sv+Sf) + 1.
//   - Same-state request: done_pulse at A+1.
//  Invariant at all times: voltage_override >= frequency_override.
//  Budget changes during a transition do not abort it; the throttle check is re-evaluated in IDLE.
//  Request inputs are ignored while busy; the bench must hold req_valid until req_ready.
// CONFIGURATION
//  DVFS_SEQ_STATS_EN defined: adds output ports
//    transition_count[15:0]  +1 per completed step, saturating at 16'hFFFF
//    throttle_count[15:0]    +1 per throttle DONE, saturating
//  Both counters reset to 0.
//  DVFS_SEQ_STATS_EN undefined: these ports and registers do not exist; all other behaviour is identical.
// TESTING
//  1. Up step: Sv=4, Sf=2, cur=0, req 1 at cycle A.
//     -> voltage_override=1 at A+2, frequency_override=1 at A+7, done_pulse at A+9.
//  2. Down 2 steps: Sv=4, Sf=2, cur=3, req 1.
//     -> frequency drops before voltage on each step, done_pulse at A+17, final cur_pstate=1.
//  3. Over budget: budget=8000, power=9000, cur=3, IDLE.
//     -> req_ready=0, throttle_active=1, done_pulse with cur_pstate=2.
//     Then req 5 while still over budget -> reject_pulse.
//  4. Illegal/no-op requests:
//     req 7 with MAX_PSTATE=6 -> reject_pulse, outputs unchanged.
//     req == cur -> done_pulse at A+1.
//  5. reset_n low mid-V_WAIT -> all outputs 0 and req_ready=1 immediately.
//     After release, req 2 completes normally.
//  6. Invariant checker: voltage_override >= frequency_override every cycle across a random request stream.
//     With DVFS_SEQ_STATS_EN, transition_count equals the total number of steps taken.

Source files
------------

// File: rtl/dvfs_pstate_sequencer.sv
// Steps P-state overrides one code at a time with safe V/F ordering and settle waits.
// Optional stats counters enabled by defining DVFS_SEQ_STATS_EN.
module dvfs_pstate_sequencer #(
   parameter int PSTATE_W   = 3,
   parameter int MAX_PSTATE = 6,
   parameter int SETTLE_W   = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [PSTATE_W-1:0] req_pstate,
   input  logic [15:0]         power_budget_mw,
   input  logic [15:0]         current_power_mw,
   input  logic [SETTLE_W-1:0] volt_settle_cycles,
   input  logic [SETTLE_W-1:0] freq_settle_cycles,
   output logic                frequency_override_en,
   output logic [PSTATE_W-1:0] frequency_override,
   output logic                voltage_override_en,
   output logic [PSTATE_W-1:0] voltage_override,
   output logic [PSTATE_W-1:0] cur_pstate,
   output logic                busy,
   output logic                done_pulse,
   output logic                reject_pulse,
`ifdef DVFS_SEQ_STATS_EN
   output logic [15:0]         transition_count,
   output logic [15:0]         throttle_count,
`endif
   output logic                throttle_active
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_V_STEP,
      S_V_WAIT,
      S_F_STEP,
      S_F_WAIT,
      S_DONE
   } state_t;

   localparam logic [PSTATE_W-1:0] LP_MAX = PSTATE_W'(MAX_PSTATE);
   localparam logic [PSTATE_W-1:0] LP_P1  = PSTATE_W'(1);
   localparam logic [SETTLE_W-1:0] LP_ONE = SETTLE_W'(1);

   state_t              r_state;
   state_t              w_next;
   logic [PSTATE_W-1:0] r_freq;
   logic [PSTATE_W-1:0] r_volt;
   logic [PSTATE_W-1:0] r_target;
   logic [PSTATE_W-1:0] w_target_n;
   logic                r_dir_up;
   logic                w_dir_up_n;
   logic                r_fen;
   logic                r_ven;
   logic [SETTLE_W-1:0] r_cnt;
   logic                r_reject;
   logic                r_throttle;
   logic                w_reject;
   logic                w_thr_start;

   logic                w_over;
   logic                w_thr;
   logic                w_cnt_last;
   logic                w_at_tgt;
   logic                w_step_done;
   logic [SETTLE_W-1:0] w_vload;
   logic [SETTLE_W-1:0] w_fload;

   assign w_over     = current_power_mw > power_budget_mw;
   assign w_thr      = w_over && (r_freq != '0);
   assign w_cnt_last = r_cnt == LP_ONE;
   assign w_at_tgt   = r_freq == r_target;
   assign w_vload    = (volt_settle_cycles == '0) ? LP_ONE : volt_settle_cycles;
   assign w_fload    = (freq_settle_cycles == '0) ? LP_ONE : freq_settle_cycles;

   // A step is complete after the second half of its V/F pair has settled.
   assign w_step_done = w_cnt_last &&
      ((r_state == S_F_WAIT && r_dir_up) ||
       (r_state == S_V_WAIT && !r_dir_up));

   assign req_ready             = (r_state == S_IDLE) && !w_thr;
   assign busy                  = r_state != S_IDLE;
   assign done_pulse            = r_state == S_DONE;
   assign reject_pulse          = r_reject;
   assign throttle_active       = r_throttle;
   assign frequency_override    = r_freq;
   assign frequency_override_en = r_fen;
   assign voltage_override      = r_volt;
   assign voltage_override_en   = r_ven;
   assign cur_pstate            = r_freq;

   always_comb begin
      w_next      = r_state;
      w_target_n  = r_target;
      w_dir_up_n  = r_dir_up;
      w_reject    = 1'b0;
      w_thr_start = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_thr) begin
               w_next      = S_F_STEP;
               w_target_n  = r_freq - LP_P1;
               w_dir_up_n  = 1'b0;
               w_thr_start = 1'b1;
            end else if (req_valid) begin
               if (req_pstate > LP_MAX ||
                   (w_over && req_pstate > r_freq)) begin
                  w_reject = 1'b1;
               end else if (req_pstate == r_freq) begin
                  w_next = S_DONE;
               end else begin
                  w_target_n = req_pstate;
                  w_dir_up_n = req_pstate > r_freq;
                  w_next     = (req_pstate > r_freq) ? S_V_STEP : S_F_STEP;
               end
            end
         end
         S_V_STEP: w_next = S_V_WAIT;
         S_F_STEP: w_next = S_F_WAIT;
         S_V_WAIT: begin
            if (w_cnt_last)
               w_next = (!r_dir_up && w_at_tgt) ? S_DONE : S_F_STEP;
         end
         S_F_WAIT: begin
            if (w_cnt_last)
               w_next = (r_dir_up && w_at_tgt) ? S_DONE : S_V_STEP;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_freq     <= '0;
         r_volt     <= '0;
         r_target   <= '0;
         r_dir_up   <= 1'b0;
         r_fen      <= 1'b0;
         r_ven      <= 1'b0;
         r_cnt      <= '0;
         r_reject   <= 1'b0;
         r_throttle <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_target <= w_target_n;
         r_dir_up <= w_dir_up_n;
         r_reject <= w_reject;
         if (w_thr_start)
            r_throttle <= 1'b1;
         else if (r_state == S_DONE)
            r_throttle <= 1'b0;
         unique case (r_state)
            S_V_STEP: begin
               r_volt <= r_dir_up ? r_volt + LP_P1 : r_volt - LP_P1;
               r_ven  <= 1'b1;
               r_cnt  <= w_vload;
            end
            S_F_STEP: begin
               r_freq <= r_dir_up ? r_freq + LP_P1 : r_freq - LP_P1;
               r_fen  <= 1'b1;
               r_cnt  <= w_fload;
            end
            S_V_WAIT, S_F_WAIT: r_cnt <= r_cnt - LP_ONE;
            default: ;
         endcase
      end
   end

`ifdef DVFS_SEQ_STATS_EN
   logic [15:0] r_trans_cnt;
   logic [15:0] r_thr_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_trans_cnt <= '0;
         r_thr_cnt   <= '0;
      end else begin
         if (w_step_done && r_trans_cnt != 16'hFFFF)
            r_trans_cnt <= r_trans_cnt + 16'd1;
         if (r_state == S_DONE && r_throttle && r_thr_cnt != 16'hFFFF)
            r_thr_cnt <= r_thr_cnt + 16'd1;
      end
   end

   assign transition_count = r_trans_cnt;
   assign throttle_count   = r_thr_cnt;
`endif

endmodule

// File: tb/tb_dvfs_pstate_sequencer.sv
// Directed bench for dvfs_pstate_sequencer: latencies, ordering, throttle,
// rejects, async reset and a random request stream with an ordering invariant.
module tb_dvfs_pstate_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_pstate;
   logic [15:0] power_budget_mw;
   logic [15:0] current_power_mw;
   logic [7:0]  volt_settle_cycles;
   logic [7:0]  freq_settle_cycles;
   logic        frequency_override_en;
   logic [2:0]  frequency_override;
   logic        voltage_override_en;
   logic [2:0]  voltage_override;
   logic [2:0]  cur_pstate;
   logic        busy;
   logic        done_pulse;
   logic        reject_pulse;
   logic        throttle_active;
`ifdef DVFS_SEQ_STATS_EN
   logic [15:0] transition_count;
   logic [15:0] throttle_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int steps = 0;

   always #5 clk = ~clk;

   dvfs_pstate_sequencer dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .req_valid             (req_valid),
      .req_ready             (req_ready),
      .req_pstate            (req_pstate),
      .power_budget_mw       (power_budget_mw),
      .current_power_mw      (current_power_mw),
      .volt_settle_cycles    (volt_settle_cycles),
      .freq_settle_cycles    (freq_settle_cycles),
      .frequency_override_en (frequency_override_en),
      .frequency_override    (frequency_override),
      .voltage_override_en   (voltage_override_en),
      .voltage_override      (voltage_override),
      .cur_pstate            (cur_pstate),
      .busy                  (busy),
      .done_pulse            (done_pulse),
      .reject_pulse          (reject_pulse),
`ifdef DVFS_SEQ_STATS_EN
      .transition_count      (transition_count),
      .throttle_count        (throttle_count),
`endif
      .throttle_active       (throttle_active)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      chk("v_ge_f", {31'b0, voltage_override >= frequency_override}, 1);
   endtask

   task automatic wait_done(input int n0, output int n);
      n = n0;
      while (!done_pulse && n < 200) begin
         tick();
         n++;
      end
   endtask

   // Returns in cycle A+1, where A is the accept cycle.
   task automatic do_req(input logic [2:0] p);
      int w;
      w = 0;
      req_valid  = 1'b1;
      req_pstate = p;
      while (!req_ready && w < 200) begin
         tick();
         w++;
      end
      chk("req_ready_wait", req_ready, 1);
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      int n;
      int cur;
      int p;
      int sv;
      int sf;
      int k;
      reset_n            = 1'b0;
      req_valid          = 1'b0;
      req_pstate         = '0;
      power_budget_mw    = 16'hFFFF;
      current_power_mw   = 16'd0;
      volt_settle_cycles = 8'd4;
      freq_settle_cycles = 8'd2;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_freq", frequency_override, 0);
      chk("rst_volt", voltage_override, 0);
      chk("rst_fen", frequency_override_en, 0);
      chk("rst_ven", voltage_override_en, 0);
      chk("rst_done", done_pulse, 0);
      chk("rst_thr", throttle_active, 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Up one step 0 -> 1
      do_req(3'd1);
      chk("up_busy", busy, 1);
      chk("up_ready_busy", req_ready, 0);
      chk("up_volt_a1", voltage_override, 0);
      tick();
      chk("up_volt_a2", voltage_override, 1);
      chk("up_ven_a2", voltage_override_en, 1);
      chk("up_freq_a2", frequency_override, 0);
      chk("up_fen_a2", frequency_override_en, 0);
      repeat (4) tick();
      chk("up_freq_a6", frequency_override, 0);
      tick();
      chk("up_freq_a7", frequency_override, 1);
      chk("up_fen_a7", frequency_override_en, 1);
      tick();
      chk("up_done_a8", done_pulse, 0);
      tick();
      chk("up_done_a9", done_pulse, 1);
      chk("up_cur", cur_pstate, 1);
      tick();
      chk("up_idle", busy, 0);
      steps += 1;

      // Up two steps 1 -> 3
      do_req(3'd3);
      wait_done(1, n);
      chk("up2_lat", n, 17);
      chk("up2_cur", cur_pstate, 3);
      tick();
      steps += 2;

      // Down two steps 3 -> 1, frequency first
      do_req(3'd1);
      tick();
      chk("dn_freq_a2", frequency_override, 2);
      chk("dn_volt_a2", voltage_override, 3);
      repeat (2) tick();
      chk("dn_volt_a4", voltage_override, 3);
      tick();
      chk("dn_volt_a5", voltage_override, 2);
      wait_done(5, n);
      chk("dn_lat", n, 17);
      chk("dn_cur", cur_pstate, 1);
      chk("dn_volt", voltage_override, 1);
      tick();
      steps += 2;

      do_req(3'd3);
      wait_done(1, n);
      chk("up3_cur", cur_pstate, 3);
      tick();
      steps += 2;

      // Over budget: throttle repeatedly down to 0
      power_budget_mw  = 16'd8000;
      current_power_mw = 16'd9000;
      #1;
      chk("thr_ready", req_ready, 0);
      tick();
      chk("thr_active", throttle_active, 1);
      chk("thr_busy", busy, 1);
      wait_done(1, n);
      chk("thr_lat", n, 9);
      chk("thr_cur", cur_pstate, 2);
      chk("thr_volt", voltage_override, 2);
      tick();
      wait_done(1, n);
      chk("thr_cur2", cur_pstate, 1);
      tick();
      wait_done(1, n);
      chk("thr_cur3", cur_pstate, 0);
      tick();
      chk("thr_clear", throttle_active, 0);
      chk("thr_ready0", req_ready, 1);
      steps += 3;
      do_req(3'd5);
      chk("ovr_reject", reject_pulse, 1);
      chk("ovr_cur", cur_pstate, 0);
      chk("ovr_busy", busy, 0);
      tick();
      chk("ovr_reject_off", reject_pulse, 0);
`ifdef DVFS_SEQ_STATS_EN
      chk("st_trans", transition_count, steps);
      chk("st_thr", throttle_count, 3);
`endif
      current_power_mw = 16'd0;

      // Illegal and same-state requests
      do_req(3'd7);
      chk("ill_reject", reject_pulse, 1);
      chk("ill_cur", cur_pstate, 0);
      chk("ill_volt", voltage_override, 0);
      tick();
      do_req(3'd0);
      chk("same_done", done_pulse, 1);
      chk("same_busy", busy, 1);
      tick();

      // Async reset mid V_WAIT
      do_req(3'd2);
      repeat (2) tick();
      chk("mid_volt", voltage_override, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_volt", voltage_override, 0);
      chk("ar_freq", frequency_override, 0);
      chk("ar_ven", voltage_override_en, 0);
      chk("ar_fen", frequency_override_en, 0);
      chk("ar_busy", busy, 0);
      chk("ar_ready", req_ready, 1);
      chk("ar_done", done_pulse, 0);
`ifdef DVFS_SEQ_STATS_EN
      chk("ar_trans", transition_count, 0);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      steps = 0;
      tick();
      do_req(3'd2);
      wait_done(1, n);
      chk("ar_lat", n, 17);
      chk("ar_cur", cur_pstate, 2);
      tick();
      steps += 2;

      // Random request stream
      cur = 2;
      for (int i = 0; i < 8; i++) begin
         p  = int'($urandom_range(0, 6));
         sv = int'($urandom_range(0, 3));
         sf = int'($urandom_range(0, 3));
         volt_settle_cycles = 8'(sv);
         freq_settle_cycles = 8'(sf);
         if (sv == 0) sv = 1;
         if (sf == 0) sf = 1;
         k = (p > cur) ? p - cur : cur - p;
         do_req(3'(p));
         wait_done(1, n);
         chk("rnd_lat", n, (k == 0) ? 1 : k * (2 + sv + sf) + 1);
         chk("rnd_cur", cur_pstate, p);
         tick();
         steps += k;
         cur = p;
      end
`ifdef DVFS_SEQ_STATS_EN
      chk("rnd_trans", transition_count, steps);
      chk("rnd_thr", throttle_count, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
